// File: rtl/fe_mode_sequencer_pkg.sv
// fe_mode_sequencer_pkg: speed codes, FSM encodings and per-speed front-end mode constants
package fe_mode_sequencer_pkg;
  localparam logic [1:0] USB_SPEED_HS   = 2'd0;
  localparam logic [1:0] USB_SPEED_FS   = 2'd1;
  localparam logic [1:0] USB_SPEED_LS   = 2'd2;
  localparam logic [1:0] USB_SPEED_AUTO = 2'd3;
  localparam logic [1:0] ST_STABLE  = 2'd0;
  localparam logic [1:0] ST_QUIESCE = 2'd1;
  localparam logic [1:0] ST_SWITCH  = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;
  typedef struct packed {
    logic [1:0] xcvrsel;
    logic       termsel;
  } fe_mode_t;
  localparam fe_mode_t MODE_HS = '{xcvrsel: 2'b00, termsel: 1'b0};
  localparam fe_mode_t MODE_FS = '{xcvrsel: 2'b01, termsel: 1'b1};
  localparam fe_mode_t MODE_LS = '{xcvrsel: 2'b10, termsel: 1'b1};
endpackage

// File: rtl/fe_mode_sequencer_if.sv
// fe_mode_sequencer_if: control inputs and status outputs of the front-end mode sequencer
interface fe_mode_sequencer_if;
  logic [1:0] I_usb_speed;
  logic [1:0] I_auto_speed;
  logic       I_auto_done;
  logic [1:0] I_xcvrsel_auto;
  logic       I_termsel_auto;
  logic       I_reseq;
  logic       I_rxactive;
  logic [1:0] O_xcvrsel;
  logic       O_termsel;
  logic       O_capture_hold;
  logic       O_auto_restart;
  logic [1:0] O_state;
  logic       O_quiesce_timeout;
  logic [7:0] O_mode_changes;
  modport master (
    output I_usb_speed, I_auto_speed, I_auto_done, I_xcvrsel_auto, I_termsel_auto, I_reseq, I_rxactive,
    input  O_xcvrsel, O_termsel, O_capture_hold, O_auto_restart, O_state, O_quiesce_timeout, O_mode_changes
  );
  modport slave (
    input  I_usb_speed, I_auto_speed, I_auto_done, I_xcvrsel_auto, I_termsel_auto, I_reseq, I_rxactive,
    output O_xcvrsel, O_termsel, O_capture_hold, O_auto_restart, O_state, O_quiesce_timeout, O_mode_changes
  );
endinterface

// File: rtl/fe_mode_sequencer_map.sv
// fe_mode_map: speed code to {xcvrsel,termsel}; AUTO falls back to FS
module fe_mode_map
  import fe_mode_sequencer_pkg::*;
(
  input  logic [1:0] speed,
  output fe_mode_t   mode
);
  always_comb begin
    mode = speed == USB_SPEED_LS ? MODE_LS :
           speed == USB_SPEED_HS ? MODE_HS : MODE_FS;
  end
endmodule

// File: rtl/fe_mode_sequencer.sv
// fe_mode_sequencer: gap-aligned front-end mode switching with post-switch capture hold
module fe_mode_sequencer
  import fe_mode_sequencer_pkg::*;
#(
  parameter int unsigned pSETTLE_CYCLES   = 600,
  parameter int unsigned pQUIESCE_TIMEOUT = 60000,
  parameter int unsigned pCNT_WIDTH       = 16
) (
  input logic fe_clk,
  input logic reset_i,
  fe_mode_sequencer_if.slave bus
);
  localparam logic [pCNT_WIDTH-1:0] SETTLE_LAST  = pCNT_WIDTH'(pSETTLE_CYCLES - 1);
  localparam logic [pCNT_WIDTH-1:0] TIMEOUT_LAST = pCNT_WIDTH'(pQUIESCE_TIMEOUT - 1);
  fe_mode_t reg_mode, auto_mode, target;
  logic [1:0] state_q, state_d, speed_q, speed_d;
  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
  fe_mode_t mode_q, mode_d;
  logic [7:0] changes_q, changes_d;
  logic timeout_q, timeout_d, rx_low_q, rx_low_d, restart_q, restart_d;
  logic is_auto;
  fe_mode_map u_reg_map  (.speed(bus.I_usb_speed),  .mode(reg_mode));
  fe_mode_map u_auto_map (.speed(bus.I_auto_speed), .mode(auto_mode));
  assign is_auto = bus.I_usb_speed == USB_SPEED_AUTO;
  assign target  = !is_auto ? reg_mode :
                   bus.I_auto_done ? auto_mode : fe_mode_t'({bus.I_xcvrsel_auto, bus.I_termsel_auto});
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    mode_d    = mode_q;
    changes_d = changes_q;
    timeout_d = timeout_q & ~bus.I_reseq;
    rx_low_d  = state_q == ST_QUIESCE && !bus.I_rxactive;
    speed_d   = bus.I_usb_speed;
    restart_d = is_auto && (speed_q != USB_SPEED_AUTO || bus.I_reseq);
    case (state_q)
      ST_STABLE: begin
        cnt_d   = '0;
        state_d = (target != mode_q || bus.I_reseq) ? ST_QUIESCE : ST_STABLE;
      end
      ST_QUIESCE: begin
        // a real gap wins over the timeout, so the sticky flag only marks forced switches
        if (!bus.I_rxactive && rx_low_q) state_d = ST_SWITCH;
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_SWITCH;
          timeout_d = 1'b1;
        end
      end
      ST_SWITCH: begin
        state_d   = ST_SETTLE;
        cnt_d     = '0;
        mode_d    = target;
        changes_d = changes_q + 8'(changes_q != 8'hFF);
      end
      default: begin
        if (bus.I_reseq) cnt_d = '0;
        else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
    endcase
  end
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      mode_q    <= MODE_FS;
      changes_q <= '0;
      timeout_q <= 1'b0;
      rx_low_q  <= 1'b0;
      speed_q   <= USB_SPEED_FS;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      changes_q <= changes_d;
      timeout_q <= timeout_d;
      rx_low_q  <= rx_low_d;
      speed_q   <= speed_d;
      restart_q <= restart_d;
    end
  end
  assign bus.O_xcvrsel         = mode_q.xcvrsel;
  assign bus.O_termsel         = mode_q.termsel;
  assign bus.O_capture_hold    = state_q != ST_STABLE;
  assign bus.O_auto_restart    = restart_q;
  assign bus.O_state           = state_q;
  assign bus.O_quiesce_timeout = timeout_q;
  assign bus.O_mode_changes    = changes_q;
endmodule

// File: tb/tb_fe_mode_sequencer.sv
// tb_fe_mode_sequencer: directed vectors with hand-computed expectations for fe_mode_sequencer
module tb_fe_mode_sequencer;
  logic fe_clk = 1'b0;
  logic reset_i = 1'b1;
  int tests = 0;
  int errs = 0;
  fe_mode_sequencer_if bus();
  fe_mode_sequencer dut (.fe_clk(fe_clk), .reset_i(reset_i), .bus(bus));
  always #5 fe_clk = ~fe_clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge fe_clk);
    #1;
  endtask
  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (bus.O_state != s && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 8'(bus.O_state), 8'(s));
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 8'(bus.O_state), 8'd3);
    chk({tag, "_xcvr"}, 8'(bus.O_xcvrsel), 8'd1);
    chk({tag, "_term"}, 8'(bus.O_termsel), 8'd1);
    chk({tag, "_hold"}, 8'(bus.O_capture_hold), 8'd1);
    chk({tag, "_restart"}, 8'(bus.O_auto_restart), 8'd0);
    chk({tag, "_timeout"}, 8'(bus.O_quiesce_timeout), 8'd0);
    chk({tag, "_changes"}, bus.O_mode_changes, 8'd0);
  endtask
  initial begin
    bus.I_usb_speed    = 2'd1;
    bus.I_auto_speed   = 2'd0;
    bus.I_auto_done    = 1'b0;
    bus.I_xcvrsel_auto = 2'b00;
    bus.I_termsel_auto = 1'b0;
    bus.I_reseq        = 1'b0;
    bus.I_rxactive     = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    reset_i = 1'b0;
    tick(599);
    chk("rst_hold599", 8'(bus.O_capture_hold), 8'd1);
    tick(1);
    chk("rst_hold600", 8'(bus.O_capture_hold), 8'd0);
    chk("rst_stable", 8'(bus.O_state), 8'd0);
    chk("rst_xcvr_fs", 8'(bus.O_xcvrsel), 8'd1);
    chk("rst_changes", bus.O_mode_changes, 8'd0);
    // FS -> HS with an idle bus
    bus.I_usb_speed = 2'd0;
    tick(1);
    chk("hs_quiesce", 8'(bus.O_state), 8'd1);
    chk("hs_hold", 8'(bus.O_capture_hold), 8'd1);
    tick(1);
    chk("hs_quiesce2", 8'(bus.O_state), 8'd1);
    tick(1);
    chk("hs_switch", 8'(bus.O_state), 8'd2);
    chk("hs_xcvr_pre", 8'(bus.O_xcvrsel), 8'd1);
    tick(1);
    chk("hs_settle", 8'(bus.O_state), 8'd3);
    chk("hs_xcvr", 8'(bus.O_xcvrsel), 8'd0);
    chk("hs_term", 8'(bus.O_termsel), 8'd0);
    chk("hs_changes", bus.O_mode_changes, 8'd1);
    tick(599);
    chk("hs_hold599", 8'(bus.O_capture_hold), 8'd1);
    tick(1);
    chk("hs_hold600", 8'(bus.O_capture_hold), 8'd0);
    // HS -> FS with rxactive stuck high: forced switch
    bus.I_usb_speed = 2'd1;
    bus.I_rxactive  = 1'b1;
    tick(1);
    chk("to_quiesce", 8'(bus.O_state), 8'd1);
    tick(59999);
    chk("to_still_quiesce", 8'(bus.O_state), 8'd1);
    chk("to_flag_pre", 8'(bus.O_quiesce_timeout), 8'd0);
    tick(1);
    chk("to_switch", 8'(bus.O_state), 8'd2);
    chk("to_flag", 8'(bus.O_quiesce_timeout), 8'd1);
    bus.I_rxactive = 1'b0;
    tick(1);
    chk("to_xcvr", 8'(bus.O_xcvrsel), 8'd1);
    chk("to_changes", bus.O_mode_changes, 8'd2);
    bus.I_reseq = 1'b1;
    tick(1);
    bus.I_reseq = 1'b0;
    chk("to_cleared", 8'(bus.O_quiesce_timeout), 8'd0);
    chk("to_restart_none", 8'(bus.O_auto_restart), 8'd0);
    tick(599);
    chk("reseq_settle599", 8'(bus.O_state), 8'd3);
    tick(1);
    chk("reseq_settle600", 8'(bus.O_state), 8'd0);
    // FS -> AUTO, undetermined, then detection reports HS
    bus.I_usb_speed    = 2'd3;
    bus.I_xcvrsel_auto = 2'b10;
    bus.I_termsel_auto = 1'b1;
    tick(1);
    chk("auto_restart", 8'(bus.O_auto_restart), 8'd1);
    chk("auto_quiesce", 8'(bus.O_state), 8'd1);
    tick(1);
    chk("auto_restart_end", 8'(bus.O_auto_restart), 8'd0);
    tick(1);
    chk("auto_switch", 8'(bus.O_state), 8'd2);
    tick(1);
    chk("auto_xcvr", 8'(bus.O_xcvrsel), 8'd2);
    chk("auto_term", 8'(bus.O_termsel), 8'd1);
    chk("auto_changes", bus.O_mode_changes, 8'd3);
    tick(600);
    chk("auto_stable", 8'(bus.O_state), 8'd0);
    bus.I_auto_done  = 1'b1;
    bus.I_auto_speed = 2'd0;
    tick(1);
    chk("det_quiesce", 8'(bus.O_state), 8'd1);
    chk("det_restart_none", 8'(bus.O_auto_restart), 8'd0);
    wait_state(2'd3, 10, "det_settle");
    chk("det_xcvr", 8'(bus.O_xcvrsel), 8'd0);
    chk("det_term", 8'(bus.O_termsel), 8'd0);
    chk("det_changes", bus.O_mode_changes, 8'd4);
    tick(600);
    chk("det_stable", 8'(bus.O_state), 8'd0);
    // back to FS, then HS requested while settling
    bus.I_usb_speed = 2'd1;
    tick(1);
    wait_state(2'd3, 10, "mid_settle");
    chk("mid_xcvr_fs", 8'(bus.O_xcvrsel), 8'd1);
    chk("mid_changes5", bus.O_mode_changes, 8'd5);
    tick(100);
    bus.I_usb_speed = 2'd0;
    tick(10);
    chk("mid_still_settle", 8'(bus.O_state), 8'd3);
    chk("mid_no_apply", 8'(bus.O_xcvrsel), 8'd1);
    tick(489);
    chk("mid_settle_end", 8'(bus.O_state), 8'd3);
    tick(1);
    chk("mid_stable", 8'(bus.O_state), 8'd0);
    chk("mid_stable_hold", 8'(bus.O_capture_hold), 8'd0);
    chk("mid_stable_xcvr", 8'(bus.O_xcvrsel), 8'd1);
    tick(1);
    chk("mid_requiesce", 8'(bus.O_state), 8'd1);
    wait_state(2'd3, 10, "mid_settle2");
    chk("mid_xcvr_hs", 8'(bus.O_xcvrsel), 8'd0);
    chk("mid_term_hs", 8'(bus.O_termsel), 8'd0);
    chk("mid_changes6", bus.O_mode_changes, 8'd6);
    wait_state(2'd0, 700, "mid_final_stable");
    // async reset in QUIESCE, then again mid-SETTLE
    bus.I_usb_speed = 2'd1;
    bus.I_rxactive  = 1'b1;
    tick(1);
    chk("ar_quiesce", 8'(bus.O_state), 8'd1);
    reset_i = 1'b1;
    #1;
    chk_reset_vals("ar_q");
    reset_i = 1'b0;
    bus.I_rxactive  = 1'b0;
    bus.I_usb_speed = 2'd0;
    wait_state(2'd2, 700, "ar_switch");
    tick(1);
    chk("ar_hs_xcvr", 8'(bus.O_xcvrsel), 8'd0);
    chk("ar_hs_changes", bus.O_mode_changes, 8'd1);
    tick(300);
    reset_i = 1'b1;
    #1;
    chk_reset_vals("ar_s");
    reset_i = 1'b0;
    bus.I_usb_speed = 2'd1;
    tick(600);
    chk("ar_final_stable", 8'(bus.O_state), 8'd0);
    chk("ar_final_xcvr", 8'(bus.O_xcvrsel), 8'd1);
    chk("ar_final_changes", bus.O_mode_changes, 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
